cell_tile_render: RTL and testbench
===================================

# cell_tile_render

Expands one 4-bit cell code {rotation[3:2], type[1:0]}, the code the neighbourhood classifier produces, into a TILE×TILE monochrome bitmap. The bitmap is streamed one row per beat. The block sits between the cell-code store and the tile rasterizer/framebuffer writer. It accepts codes over a valid/ready handshake and emits rows over a second valid/ready handshake with backpressure.

## Interface
- TILE, 8, tile edge in pixels; power of two, ≥4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in  in  4  cell code: in[3:2] = rotation r, in[1:0] = type t
- in_valid  in  1  code present
- in_ready  out  1  block can accept a code
- out  out  TILE  pixel row; out[x] = pixel at column x (x=0 leftmost)
- out_row_idx  out  log2(TILE)  row number y (0 = top)
- out_last  out  1  high on row TILE-1
- out_valid  out  1  row present
- out_ready  in  1  downstream accepts row

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the code, set row=0, go to SEND.
  - SEND: in_ready=0, out_valid=1. On out_valid&&out_ready: if row==TILE-1, go to IDLE; else row+1.
- Pixel (x,y) is evaluated on base coords (u,v); H=TILE/2, Q=TILE/4.
- Rotation is 90° counter-clockwise per step, matching the classifier (right→top→left→bottom):
  - r=0: u=x, v=y
  - r=1: u=TILE-1-y, v=x
  - r=2: u=TILE-1-x, v=TILE-1-y
  - r=3: u=y, v=TILE-1-x
- Base shapes (r=0):
  - t=0 (empty): 0
  - t=1 (edge bar toward right): Q≤v<3Q and u≥Q
  - t=2 (diagonal, top-right): u≥v
  - t=3 (L, left+bottom filled): u<H or v≥H
- All arithmetic is unsigned at log2(TILE) bits; no wrap occurs in valid index ranges.
- Latched code and row counter change only on the handshakes above. Changes on `in` while in SEND are ignored.

## Timing
- Reset (async, immediate):
  - state=IDLE, row=0; out=0, out_row_idx=0, out_last=0, out_valid=0.
  - in_ready forced 0 while rst is high; it rises the first cycle after rst deasserts.
- Outputs out, out_row_idx and out_last are registered. They are held stable while out_valid && !out_ready.
- Latency: code accepted at edge k → out_valid=1 with row 0 after edge k (cycle k+1).
- Row y+1 is presented the cycle after row y's handshake.
- After the out_last handshake, out_valid=0 and in_ready=1 in the next cycle.
- Minimum period is TILE+1 cycles per tile. Accept and emit never overlap.
- Reset mid-tile aborts the tile. No partial-tile resume.

## Configuration
- CELL_TILE_RENDER_SKIP_EMPTY_EN:
  - Defined: a t=0 code is consumed in IDLE and dropped. State stays IDLE, in_ready stays 1, no rows are emitted.
  - Undefined: a t=0 code emits TILE rows of all zeros like any other code.

## Test plan
(All scenarios use TILE=8.)
- Code 4'b0001, out_ready=1:
  - rows 0,1 = 8'h00; rows 2–5 = 8'hFC; rows 6,7 = 8'h00
  - out_last only on row 7; in_ready=1 the cycle after row 7
- Code 4'b0110 (r=1, t=2): row y = bits 0..7-y set, i.e. row0=8'hFF, row1=8'h7F … row7=8'h01.
- Code 4'b0011 (r=0, t=3): rows 0–3 = 8'h0F, rows 4–7 = 8'hFF.
  - Same shape with 4'b1011 (r=2): rows 0–3 = 8'hFF, rows 4–7 = 8'hF0.
- Backpressure: code 4'b0001, out_ready=0 for 3 cycles while row 3 is shown:
  - out=8'hFC and out_row_idx=3 are held
  - in_ready stays 0 and a new in_valid is ignored
  - then completes rows 4–7
- Reset mid-tile: assert rst while row 5 is shown:
  - out_valid=0 and out_row_idx=0 immediately
  - after release, code 4'b0011 starts again at row 0 = 8'h0F
- Code 4'b0000:
  - with the macro undefined, 8 rows of 8'h00
  - with the macro defined, no out_valid; an immediately following 4'b0001 is accepted the next cycle

Source files
------------

// File: rtl/cell_tile_render.sv
// Expands a 4-bit cell code {rotation, type} into a TILE x TILE monochrome bitmap, one row per beat.
// Optional macro CELL_TILE_RENDER_SKIP_EMPTY_EN: drop empty (type 0) codes in IDLE instead of emitting blank rows.
module cell_tile_render #(
    parameter int TILE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [TILE-1:0]         out,
    output logic [$clog2(TILE)-1:0] out_row_idx,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int W = $clog2(TILE);
    typedef logic [W-1:0] idx_t;

    localparam idx_t MAX_IDX = idx_t'(TILE - 1);
    localparam idx_t HALF    = idx_t'(TILE / 2);
    localparam idx_t QTR     = idx_t'(TILE / 4);
    localparam idx_t QTR3    = idx_t'(3 * TILE / 4);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state, state_d;
    logic [3:0] code;
    idx_t       row;
    logic       accept, drop, advance;

    // Rotate (x,y) into base coordinates (u,v), then evaluate the base shape.
    function automatic logic [TILE-1:0] render_row(input logic [3:0] c, input idx_t y);
        logic [TILE-1:0] bits;
        idx_t            x, u, v;
        bits = '0;
        for (int i = 0; i < TILE; i++) begin
            x = idx_t'(i);
            case (c[3:2])
                2'd0:    begin u = x;           v = y;           end
                2'd1:    begin u = MAX_IDX - y; v = x;           end
                2'd2:    begin u = MAX_IDX - x; v = MAX_IDX - y; end
                default: begin u = y;           v = MAX_IDX - x; end
            endcase
            case (c[1:0])
                2'd0:    bits[i] = 1'b0;
                2'd1:    bits[i] = (v >= QTR) && (v < QTR3) && (u >= QTR);
                2'd2:    bits[i] = (u >= v);
                default: bits[i] = (u < HALF) || (v >= HALF);
            endcase
        end
        return bits;
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == SEND);
    assign out_row_idx = row;

    // NOTE: every signal written in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state;
        accept  = (state == IDLE) && in_valid && in_ready;
        advance = (state == SEND) && out_ready;
`ifdef CELL_TILE_RENDER_SKIP_EMPTY_EN
        drop    = accept && (in[1:0] == 2'd0);
`else
        drop    = 1'b0;
`endif
        case (state)
            IDLE:    if (accept && !drop) state_d = SEND;
            SEND:    if (advance && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code     <= '0;
            row      <= '0;
            out      <= '0;
            out_last <= 1'b0;
        end else if (accept && !drop) begin
            code     <= in;
            row      <= '0;
            out      <= render_row(in, '0);
            out_last <= 1'b0;
        end else if (advance) begin
            if (out_last) begin
                row      <= '0;
                out      <= '0;
                out_last <= 1'b0;
            end else begin
                row      <= row + 1'b1;
                out      <= render_row(code, row + 1'b1);
                out_last <= (row + 1'b1 == MAX_IDX);
            end
        end
    end

endmodule

// File: tb/tb_cell_tile_render.sv
// Directed self-checking bench for cell_tile_render (TILE=8): shapes, rotation, backpressure, reset, empty code.
module tb_cell_tile_render;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic [2:0] out_row_idx;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    cell_tile_render #(.TILE(8)) dut (
        .clk(clk), .rst(rst),
        .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_row_idx(out_row_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one code for a single cycle; it must be accepted on that edge.
    task automatic send_code(input logic [3:0] c);
        in       = c;
        in_valid = 1'b1;
        check($sformatf("in_ready before code %b", c), 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Check rows first..7 with out_ready=1, then the return to IDLE.
    task automatic expect_rows(input string tag, input logic [7:0] exp_rows [8], input int first);
        out_ready = 1'b1;
        for (int y = first; y < 8; y++) begin
            check($sformatf("%s valid y%0d", tag, y), 32'(out_valid), 32'd1);
            check($sformatf("%s row y%0d", tag, y), 32'(out), 32'(exp_rows[y]));
            check($sformatf("%s idx y%0d", tag, y), 32'(out_row_idx), 32'(y));
            check($sformatf("%s last y%0d", tag, y), 32'(out_last), 32'(y == 7));
            check($sformatf("%s in_ready y%0d", tag, y), 32'(in_ready), 32'd0);
            step();
        end
        check($sformatf("%s valid after last", tag), 32'(out_valid), 32'd0);
        check($sformatf("%s in_ready after last", tag), 32'(in_ready), 32'd1);
    endtask

    logic [7:0] bar_rows  [8] = '{8'h00, 8'h00, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'h00, 8'h00};
    logic [7:0] diag_rows [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    logic [7:0] l_rows    [8] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] l180_rows [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    logic [7:0] zero_rows [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        rst       = 1'b1;
        in        = 4'b0000;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out", 32'(out), 32'd0);
        check("reset idx", 32'(out_row_idx), 32'd0);
        check("reset last", 32'(out_last), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        send_code(4'b0001);
        expect_rows("bar", bar_rows, 0);

        send_code(4'b0110);
        expect_rows("diag_r1", diag_rows, 0);

        send_code(4'b0011);
        expect_rows("l_r0", l_rows, 0);

        send_code(4'b1011);
        expect_rows("l_r2", l180_rows, 0);

        // Backpressure on row 3 while a competing code is offered.
        send_code(4'b0001);
        for (int y = 0; y < 3; y++) step();
        out_ready = 1'b0;
        in        = 4'b0011;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp valid k%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp out k%0d", k), 32'(out), 32'hFC);
            check($sformatf("bp idx k%0d", k), 32'(out_row_idx), 32'd3);
            check($sformatf("bp in_ready k%0d", k), 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        expect_rows("bp", bar_rows, 3);

        // Reset while row 5 is shown aborts the tile.
        send_code(4'b0011);
        for (int y = 0; y < 5; y++) step();
        check("pre-reset idx", 32'(out_row_idx), 32'd5);
        rst = 1'b1;
        #1;
        check("mid reset valid", 32'(out_valid), 32'd0);
        check("mid reset idx", 32'(out_row_idx), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        send_code(4'b0011);
        expect_rows("after_reset", l_rows, 0);

        // Empty code.
        send_code(4'b0000);
`ifdef CELL_TILE_RENDER_SKIP_EMPTY_EN
        check("skip valid", 32'(out_valid), 32'd0);
        check("skip in_ready", 32'(in_ready), 32'd1);
        send_code(4'b0001);
        expect_rows("after_skip", bar_rows, 0);
`else
        expect_rows("empty", zero_rows, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
